// File: rtl/adder_subtractor_pkg.sv
// Shared types and constants for the adder/subtractor: width default, group size,
// registered flag bundle and the group carry equation used at both levels of the chain.
`ifndef ADDER_WIDTH
`define ADDER_WIDTH 32
`endif

package adder_subtractor_pkg;

`ifdef CUSTOM_DEFINE
    localparam int DEFAULT_ADDER_WIDTH = `ADDER_WIDTH;
`else
    localparam int DEFAULT_ADDER_WIDTH = 32;
`endif

    localparam int GROUP_WIDTH = 4;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    // An all-zero sum is what reset leaves on the output, so zero reads high.
    localparam flags_t FLAGS_RESET = '{cout: 1'b0, overflow: 1'b0, zero: 1'b1, negative: 1'b0};

    function automatic logic group_carry(input logic g, input logic p, input logic cin);
        return g | (p & cin);
    endfunction

endpackage

// File: rtl/adder_subtractor_cla_4bit.sv
// 4-bit carry-lookahead slice: internal carries are flattened sums of products,
// and the slice exports its group generate/propagate for the inter-group chain.
module cla_4bit
    import adder_subtractor_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       g,
    output logic       p
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [3:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    assign carry[0] = cin;
    assign carry[1] = gen[0] | (prop[0] & cin);
    assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & cin);

    assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
    assign p = &prop;

    assign s    = prop ^ carry;
    assign cout = group_carry(g, p, cin);

endmodule

// File: rtl/adder_subtractor.sv
// Registered two's-complement adder/subtractor (Cin selects subtract) built from
// 4-bit lookahead groups, with carry, overflow, zero and negative flags.
module adder_subtractor
    import adder_subtractor_pkg::*;
#(
    parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDER_WIDTH-1:0] A,
    input  logic [ADDER_WIDTH-1:0] B,
    input  logic                   Cin,
    input  logic                   valid_i,
    output logic [ADDER_WIDTH-1:0] sum,
    output logic                   Cout,
    output logic                   overflow,
    output logic                   zero,
    output logic                   negative,
    output logic                   valid_o
);

    localparam int NUM_GROUPS = ADDER_WIDTH / GROUP_WIDTH;
    localparam int MSB        = ADDER_WIDTH - 1;

    generate
        if ((ADDER_WIDTH % GROUP_WIDTH) != 0 || ADDER_WIDTH < GROUP_WIDTH) begin : g_bad_width
            $error("adder_subtractor: ADDER_WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [ADDER_WIDTH-1:0] bx;
    logic [ADDER_WIDTH-1:0] raw_sum;
    logic [NUM_GROUPS:0]    carry;
    logic [NUM_GROUPS-1:0]  group_g;
    logic [NUM_GROUPS-1:0]  group_p;
    // The slice carry-outs equal the G/P chain below; the chain is what feeds forward.
    logic [NUM_GROUPS-1:0]  group_cout_unused;

    assign bx       = B ^ {ADDER_WIDTH{Cin}};
    assign carry[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
            cla_4bit u_cla (
                .a    (A[gi*GROUP_WIDTH +: GROUP_WIDTH]),
                .b    (bx[gi*GROUP_WIDTH +: GROUP_WIDTH]),
                .cin  (carry[gi]),
                .s    (raw_sum[gi*GROUP_WIDTH +: GROUP_WIDTH]),
                .cout (group_cout_unused[gi]),
                .g    (group_g[gi]),
                .p    (group_p[gi])
            );
            assign carry[gi+1] = group_carry(group_g[gi], group_p[gi], carry[gi]);
        end
    endgenerate

    flags_t                 flags_new;
    flags_t                 flags_d;
    flags_t                 flags_q;
    logic [ADDER_WIDTH-1:0] sum_d;
    logic [ADDER_WIDTH-1:0] sum_q;
    logic                   valid_d;
    logic                   valid_q;

    always_comb begin
        flags_new          = FLAGS_RESET;
        flags_new.cout     = carry[NUM_GROUPS];
        // Signed overflow: operands agree in sign but the result does not.
        flags_new.overflow = (A[MSB] == bx[MSB]) && (raw_sum[MSB] != A[MSB]);
        flags_new.zero     = (raw_sum == '0);
        flags_new.negative = raw_sum[MSB];
    end

    always_comb begin
        sum_d   = sum_q;
        flags_d = flags_q;
        valid_d = valid_i;
        if (valid_i) begin
            sum_d   = raw_sum;
            flags_d = flags_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            flags_q <= FLAGS_RESET;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign sum      = sum_q;
    assign Cout     = flags_q.cout;
    assign overflow = flags_q.overflow;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed and randomized checks of the registered adder/subtractor at the default width.
module tb_adder_subtractor;

    logic        clk;
    logic        rst;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        cin_in;
    logic        valid_in;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;
    logic        negative;
    logic        valid_o;

    int checks   = 0;
    int failures = 0;

    adder_subtractor dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a_in),
        .B        (b_in),
        .Cin      (cin_in),
        .valid_i  (valid_in),
        .sum      (sum),
        .Cout     (cout),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative),
        .valid_o  (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [31:0] es,
                              input logic ec, input logic eo, input logic ez, input logic en);
        check({tag, ".valid_o"},  {63'd0, valid_o},  {63'd0, ev});
        check({tag, ".sum"},      {32'd0, sum},      {32'd0, es});
        check({tag, ".cout"},     {63'd0, cout},     {63'd0, ec});
        check({tag, ".overflow"}, {63'd0, overflow}, {63'd0, eo});
        check({tag, ".zero"},     {63'd0, zero},     {63'd0, ez});
        check({tag, ".negative"}, {63'd0, negative}, {63'd0, en});
    endtask

    task automatic step(input logic r, input logic v, input logic c,
                        input logic [31:0] a, input logic [31:0] b);
        rst      = r;
        valid_in = v;
        cin_in   = c;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        $display("txn rst=%0b valid=%0b cin=%0b A=%08h B=%08h -> valid_o=%0b sum=%08h C=%0b V=%0b Z=%0b N=%0b",
                 r, v, c, a, b, valid_o, sum, cout, overflow, zero, negative);
    endtask

    logic [63:0] wide_a;
    logic [31:0] ra, rb, m_sum;
    logic [32:0] m_wide;
    logic        rc, rv, m_cout, m_ovf;

    initial begin
        rst = 1'b1; valid_in = 1'b0; cin_in = 1'b0; a_in = '0; b_in = '0;

        // Reset dominates valid operands.
        step(1, 1, 0, 32'd5, 32'd3);
        step(1, 1, 0, 32'd5, 32'd3);
        expect_out("reset", 0, 32'h0, 0, 0, 1, 0);

        step(0, 1, 0, 32'h0, 32'h0);
        expect_out("add_zero", 1, 32'h0, 0, 0, 1, 0);

        wide_a = 64'hAAAAAAAAFFFFFFFF;
        step(0, 1, 1, wide_a[31:0], 32'h1);
        expect_out("sub_trunc", 1, 32'hFFFFFFFE, 1, 0, 0, 1);

        step(0, 1, 0, 32'h7FFFFFFF, 32'h1);
        expect_out("add_ovf", 1, 32'h80000000, 0, 1, 0, 1);

        step(0, 1, 0, 32'hFFFFFFFF, 32'h1);
        expect_out("add_wrap", 1, 32'h0, 1, 0, 1, 0);

        step(0, 1, 1, 32'h0, 32'h1);
        expect_out("sub_borrow", 1, 32'hFFFFFFFF, 0, 0, 0, 1);

        step(0, 1, 1, 32'h80000000, 32'h1);
        expect_out("sub_ovf", 1, 32'h7FFFFFFF, 1, 1, 0, 0);

        // Back-to-back stream followed by an idle cycle that must hold the last result.
        step(0, 1, 0, 32'd10, 32'd20);
        expect_out("stream0", 1, 32'd30, 0, 0, 0, 0);
        step(0, 1, 1, 32'd100, 32'd1);
        expect_out("stream1", 1, 32'd99, 1, 0, 0, 0);
        step(0, 1, 0, 32'h12345678, 32'h11111111);
        expect_out("stream2", 1, 32'h23456789, 0, 0, 0, 0);
        step(0, 0, 1, 32'hDEADBEEF, 32'h0BADF00D);
        expect_out("hold", 0, 32'h23456789, 0, 0, 0, 0);

        // Mid-stream reset discards the operands seen on the reset edge.
        step(1, 1, 0, 32'd1, 32'd1);
        expect_out("mid_rst", 0, 32'h0, 0, 0, 1, 0);
        step(0, 0, 0, 32'd7, 32'd7);
        expect_out("post_rst_idle", 0, 32'h0, 0, 0, 1, 0);
        step(0, 1, 0, 32'd2, 32'd3);
        expect_out("post_rst_first", 1, 32'd5, 0, 0, 0, 0);

        // Randomized operands against an independent arithmetic model.
        m_sum = 32'd5; m_cout = 1'b0; m_ovf = 1'b0;
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) rb = ra;
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            if (rv) begin
                if (!rc) begin
                    m_wide = {1'b0, ra} + {1'b0, rb};
                    m_cout = m_wide[32];
                    m_sum  = m_wide[31:0];
                    m_ovf  = (ra[31] == rb[31]) && (m_sum[31] != ra[31]);
                end else begin
                    m_wide = {1'b0, ra} - {1'b0, rb};
                    m_cout = (ra >= rb);
                    m_sum  = m_wide[31:0];
                    m_ovf  = (ra[31] != rb[31]) && (m_sum[31] != ra[31]);
                end
            end
            step(0, rv, rc, ra, rb);
            expect_out($sformatf("rand%0d", i), rv, m_sum, m_cout, m_ovf, (m_sum == 32'd0), m_sum[31]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_subtractor.md
ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 Parameter ADDER_WIDTH, default 32, operand/result width; SHALL be a multiple of 4 and at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  ADDER_WIDTH  first operand.
REQ-005 B  input  ADDER_WIDTH  second operand.
REQ-006 Cin  input  1  mode select: 0 = add (A+B), 1 = subtract (A-B).
REQ-007 valid_i  input  1  operands valid this cycle.
REQ-008 sum  output  ADDER_WIDTH  registered result.
REQ-009 Cout  output  1  registered carry out of the MSB.
REQ-010 overflow  output  1  registered signed (two's-complement) overflow flag.
REQ-011 zero  output  1  registered flag: sum == 0.
REQ-012 negative  output  1  registered flag: sum[ADDER_WIDTH-1].
REQ-013 valid_o  output  1  registered; high when sum/flags hold a new result.

Function
REQ-014 Effective operand Bx SHALL be B XOR {ADDER_WIDTH{Cin}}; carry-in to bit 0 SHALL be Cin; raw result = A + Bx + Cin, modulo 2^ADDER_WIDTH.
REQ-015 Cout SHALL be the carry out of bit ADDER_WIDTH-1 of that addition; in subtract mode Cout=1 means no borrow (A >= B unsigned).
REQ-016 overflow SHALL be 1 iff A[msb] == Bx[msb] and raw result[msb] != A[msb].
REQ-017 Latency SHALL be exactly 1 cycle: operands sampled at edge N with valid_i=1 appear on sum/flags and valid_o=1 after edge N.
REQ-018 When valid_i=0 at an edge, sum and flags SHALL hold their previous values and valid_o SHALL be 0 for that cycle.
REQ-019 Back-to-back valid_i SHALL produce one result per cycle with no bubbles; no backpressure input exists.
REQ-020 Wrap-around SHALL be silent: all-ones + 1 gives sum 0, Cout 1, zero 1.
REQ-021 Carry chain SHALL be built from 4-bit carry-lookahead groups rippled group-to-group (group carry = G | P&cin).
REQ-022 Operand inputs wider than ADDER_WIDTH driven by the environment are truncated to the low ADDER_WIDTH bits.

Reset
REQ-023 On a rising edge with rst=1: sum=0, Cout=0, overflow=0, zero=1, negative=0, valid_o=0; rst SHALL override valid_i.
REQ-024 Reset asserted mid-stream SHALL discard the operands sampled at that edge; the first result after rst deasserts comes from the first valid_i edge with rst=0.

Structure
REQ-025 ADDER_WIDTH default SHALL be overridable from the shared defines header (macro ADDER_WIDTH, enabled by CUSTOM_DEFINE); no other shared constants.
REQ-026 One sub-module, cla_4bit (inputs a[3:0], b[3:0], cin; outputs s[3:0], cout, group generate, group propagate), instantiated ADDER_WIDTH/4 times via generate.
REQ-027 Overflow and zero/negative flag logic and output registers SHALL reside in adder_subtractor.

Verification
REQ-028 Reset: rst=1 for 2 cycles with valid_i=1, A=5, B=3 -> sum=0, zero=1, valid_o=0.
REQ-029 Add: A=0, B=0, Cin=0, valid_i=1 -> next cycle sum=0x00000000, zero=1, Cout=0, valid_o=1.
REQ-030 Subtract: A=0xFFFFFFFF (low 32 bits of 0xAAAAAAAAFFFFFFFF), B=0x1, Cin=1 -> sum=0xFFFFFFFE, Cout=1, negative=1, overflow=0.
REQ-031 Wrap/overflow: A=0x7FFFFFFF, B=0x1, Cin=0 -> sum=0x80000000, overflow=1, Cout=0; A=0xFFFFFFFF, B=0x1, Cin=0 -> sum=0, Cout=1, zero=1.
REQ-032 Borrow: A=0x0, B=0x1, Cin=1 -> sum=0xFFFFFFFF, Cout=0, negative=1; A=0x80000000, B=0x1, Cin=1 -> sum=0x7FFFFFFF, overflow=1.
REQ-033 Hold/stream: three back-to-back valid operand sets then valid_i=0 -> three consecutive valid_o=1 results in order, then valid_o=0 with sum held at the third result; random compare against A+B / A-B reference model.
